// File: rtl/gamma_lut_ctrl_if.sv
// gamma_lut_ctrl_if: pixel and configuration bus of gamma_lut_ctrl; cfg_rd/cfg_rdata/cfg_rvalid exist only with GAMMA_READBACK_EN
interface gamma_lut_ctrl_if #(parameter int DATA_W = 8);
  logic                  gamma_en;
  logic [3*DATA_W-1:0]   pre_rgb_data;
  logic                  pre_rgb_en;
  logic                  pre_vsync;
  logic [3*DATA_W-1:0]   post_rgb_data;
  logic                  post_rgb_en;
  logic                  post_vsync;
  logic                  cfg_we;
  logic [DATA_W+1:0]     cfg_addr;
  logic [DATA_W-1:0]     cfg_wdata;
  logic                  cfg_commit;
  logic                  cfg_busy;
  logic                  init_done;
  logic                  active_bank;
`ifdef GAMMA_READBACK_EN
  logic                  cfg_rd;
  logic [DATA_W-1:0]     cfg_rdata;
  logic                  cfg_rvalid;
`endif
  modport master (
    output gamma_en, pre_rgb_data, pre_rgb_en, pre_vsync, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
`ifdef GAMMA_READBACK_EN
    output cfg_rd,
    input  cfg_rdata, cfg_rvalid,
`endif
    input  post_rgb_data, post_rgb_en, post_vsync, cfg_busy, init_done, active_bank
  );
  modport slave (
    input  gamma_en, pre_rgb_data, pre_rgb_en, pre_vsync, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
`ifdef GAMMA_READBACK_EN
    input  cfg_rd,
    output cfg_rdata, cfg_rvalid,
`endif
    output post_rgb_data, post_rgb_en, post_vsync, cfg_busy, init_done, active_bank
  );
endinterface

// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: double-buffered RGB gamma LUT, identity self-init, bank swap on frame start after commit.
// Optional shadow-bank readback port enabled by GAMMA_READBACK_EN.
module gamma_lut_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PIPE_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  gamma_lut_ctrl_if.slave bus
);
  localparam int PW = 3 * DATA_W;
  typedef enum logic [1:0] {INIT, IDLE, PEND} state_t;
  state_t              state, state_nxt;
  logic [DATA_W-1:0]   cnt, waddr, wdata;
  logic                init_done, active_bank, vs_q, vs_rise, swap, init_wr, cfg_wr;
  logic [1:0]          ch;
  logic [PW-1:0]       pix_s1, post_data;
  logic                gam_s1, bank_s1;
  logic [PIPE_LAT-1:0] en_sr, vs_sr;
  logic [1:0][PW-1:0]  lut_word;
  assign ch      = bus.cfg_addr[DATA_W +: 2];
  assign vs_rise = bus.pre_vsync & ~vs_q;
  assign init_wr = state == INIT;
  assign cfg_wr  = state == IDLE && bus.cfg_we;
  assign waddr   = init_wr ? cnt : bus.cfg_addr[DATA_W-1:0];
  assign wdata   = init_wr ? cnt : bus.cfg_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      cnt         <= '0;
      init_done   <= 1'b0;
      active_bank <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= init_wr ? cnt + 1'b1 : '0;
      init_done   <= init_done | (init_wr && cnt == '1);
      active_bank <= active_bank ^ swap;
      vs_q        <= bus.pre_vsync;
    end
  end
  // A commit coinciding with a frame edge only arms PEND; the swap waits for the next edge.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      INIT:    state_nxt = (cnt == '1) ? IDLE : INIT;
      IDLE:    state_nxt = bus.cfg_commit ? PEND : IDLE;
      PEND: begin
        swap      = vs_rise;
        state_nxt = vs_rise ? IDLE : PEND;
      end
      default: state_nxt = INIT;
    endcase
  end
`ifdef GAMMA_READBACK_EN
  logic [1:0][DATA_W-1:0] rb_word;
  logic                   rvalid, rd_bank;
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid  <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      rvalid  <= bus.cfg_rd && state == IDLE;
      rd_bank <= ~active_bank;
    end
  end
  assign bus.cfg_rvalid = rvalid;
  assign bus.cfg_rdata  = rvalid ? rb_word[rd_bank] : '0;
`endif
  // One RAM per bank and channel; INIT fills both banks at once, config writes target the shadow bank.
  for (genvar b = 0; b < 2; b++) begin : g_b
    for (genvar c = 0; c < 3; c++) begin : g_c
      logic [DATA_W-1:0] ram [2**DATA_W];
      logic [DATA_W-1:0] q;
      logic              we;
      assign we = init_wr || (cfg_wr && active_bank != 1'(b) && (ch == 2'(c) || ch == 2'd3));
      always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        q <= ram[bus.pre_rgb_data[(3-c)*DATA_W-1 -: DATA_W]];
      end
      assign lut_word[b][(3-c)*DATA_W-1 -: DATA_W] = q;
`ifdef GAMMA_READBACK_EN
      if (c == 0) begin : g_rb
        logic [DATA_W-1:0] rb;
        always_ff @(posedge clk) rb <= ram[bus.cfg_addr[DATA_W-1:0]];
        assign rb_word[b] = rb;
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1    <= '0;
      gam_s1    <= 1'b0;
      bank_s1   <= 1'b0;
      en_sr     <= '0;
      vs_sr     <= '0;
      post_data <= '0;
    end else begin
      pix_s1    <= bus.pre_rgb_data;
      gam_s1    <= bus.gamma_en;
      bank_s1   <= active_bank;
      en_sr     <= {en_sr[PIPE_LAT-2:0], bus.pre_rgb_en};
      vs_sr     <= {vs_sr[PIPE_LAT-2:0], bus.pre_vsync};
      post_data <= gam_s1 ? lut_word[bank_s1] : pix_s1;
    end
  end
  assign bus.post_rgb_data = post_data;
  assign bus.post_rgb_en   = en_sr[PIPE_LAT-1];
  assign bus.post_vsync    = vs_sr[PIPE_LAT-1];
  assign bus.cfg_busy      = state != IDLE;
  assign bus.init_done     = init_done;
  assign bus.active_bank   = active_bank;
endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// tb_gamma_lut_ctrl: directed bench for gamma_lut_ctrl init, bank swap, commit rules, bypass and reset.
module tb_gamma_lut_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  gamma_lut_ctrl_if bus ();
  gamma_lut_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [23:0] d, input logic g, output logic [23:0] q, output logic e1, output logic e2);
    bus.pre_rgb_data = d;
    bus.gamma_en     = g;
    bus.pre_rgb_en   = 1'b1;
    tick();
    bus.pre_rgb_en = 1'b0;
    e1 = bus.post_rgb_en;
    tick();
    q  = bus.post_rgb_data;
    e2 = bus.post_rgb_en;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] idx, input logic [7:0] val);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = {ch, idx};
    bus.cfg_wdata = val;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (bus.post_rgb_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", bus.post_rgb_data); end
    checks++; if (bus.post_rgb_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.post_rgb_en); end
    checks++; if (bus.post_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", bus.post_vsync); end
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bus.cfg_busy); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", bus.init_done); end
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", bus.active_bank); end
  endtask

  task automatic test_init();
    logic [23:0] q;
    logic e1, e2;
    rst = 1'b0;
    tick(255);
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL init_busy_255: got %b want 1", bus.cfg_busy); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL init_done_255: got %b want 0", bus.init_done); end
    tick();
    checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL init_busy_256: got %b want 0", bus.cfg_busy); end
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_256: got %b want 1", bus.init_done); end
    send_pixel(24'h3C80F0, 1'b1, q, e1, e2);
    checks++; if (q !== 24'h3C80F0) begin errors++; $display("FAIL identity_pixel: got %h want 3c80f0", q); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL identity_en_lat1: got %b want 0", e1); end
    checks++; if (e2 !== 1'b1) begin errors++; $display("FAIL identity_en_lat2: got %b want 1", e2); end
  endtask

  task automatic test_swap();
    logic [23:0] q;
    logic e1, e2;
    cfg_write(2'd3, 8'h80, 8'hFF);
    do_commit();
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL swap_busy_pend: got %b want 1", bus.cfg_busy); end
    send_pixel(24'h808080, 1'b1, q, e1, e2);
    checks++; if (q !== 24'h808080) begin errors++; $display("FAIL swap_before: got %h want 808080", q); end
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL swap_bank_before: got %b want 0", bus.active_bank); end
    bus.pre_vsync = 1'b1;
    tick();
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL swap_bank_after: got %b want 1", bus.active_bank); end
    checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL swap_busy_after: got %b want 0", bus.cfg_busy); end
    checks++; if (bus.post_vsync !== 1'b0) begin errors++; $display("FAIL vsync_lat1: got %b want 0", bus.post_vsync); end
    tick();
    checks++; if (bus.post_vsync !== 1'b1) begin errors++; $display("FAIL vsync_lat2: got %b want 1", bus.post_vsync); end
    bus.pre_vsync = 1'b0;
    send_pixel(24'h808080, 1'b1, q, e1, e2);
    checks++; if (q !== 24'hFFFFFF) begin errors++; $display("FAIL swap_after: got %h want ffffff", q); end
  endtask

  task automatic test_commit_on_edge();
    logic [23:0] q;
    logic e1, e2;
    cfg_write(2'd3, 8'h80, 8'h11);
    bus.cfg_commit = 1'b1;
    bus.pre_vsync  = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL edge_no_swap: got %b want 1", bus.active_bank); end
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL edge_busy: got %b want 1", bus.cfg_busy); end
    bus.pre_vsync = 1'b0;
    tick();
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL edge_low_hold: got %b want 1", bus.active_bank); end
    bus.pre_vsync = 1'b1;
    tick();
    bus.pre_vsync = 1'b0;
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL edge_next_swap: got %b want 0", bus.active_bank); end
    send_pixel(24'h808080, 1'b1, q, e1, e2);
    checks++; if (q !== 24'h111111) begin errors++; $display("FAIL edge_pixel: got %h want 111111", q); end
  endtask

  task automatic test_write_in_pend();
    logic [23:0] q;
    logic e1, e2;
    do_commit();
    cfg_write(2'd0, 8'h10, 8'hAA);
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL pend_busy: got %b want 1", bus.cfg_busy); end
    bus.pre_vsync = 1'b1;
    tick();
    bus.pre_vsync = 1'b0;
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL pend_swap: got %b want 1", bus.active_bank); end
    send_pixel(24'h100000, 1'b1, q, e1, e2);
    checks++; if (q !== 24'h100000) begin errors++; $display("FAIL pend_write_dropped: got %h want 100000", q); end
    send_pixel(24'h808080, 1'b1, q, e1, e2);
    checks++; if (q !== 24'hFFFFFF) begin errors++; $display("FAIL pend_old_curve: got %h want ffffff", q); end
  endtask

  task automatic test_bypass();
    logic [23:0] q;
    logic e1, e2;
    send_pixel(24'h808080, 1'b0, q, e1, e2);
    checks++; if (q !== 24'h808080) begin errors++; $display("FAIL bypass_data: got %h want 808080", q); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL bypass_en_lat1: got %b want 0", e1); end
    checks++; if (e2 !== 1'b1) begin errors++; $display("FAIL bypass_en_lat2: got %b want 1", e2); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] din [4] = '{24'h808080, 24'h123456, 24'h801080, 24'h808080};
    logic        g   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        en  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [23:0] exp [4] = '{24'hFFFFFF, 24'h123456, 24'hFF10FF, 24'h808080};
    for (int j = 0; j < 5; j++) begin
      bus.pre_rgb_data = (j < 4) ? din[j] : 24'h0;
      bus.gamma_en     = (j < 4) ? g[j] : 1'b0;
      bus.pre_rgb_en   = (j < 4) ? en[j] : 1'b0;
      tick();
      if (j >= 1) begin
        checks++; if (bus.post_rgb_en !== en[j-1]) begin errors++; $display("FAIL b2b_en[%0d]: got %b want %b", j-1, bus.post_rgb_en, en[j-1]); end
        if (en[j-1]) begin
          checks++; if (bus.post_rgb_data !== exp[j-1]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", j-1, bus.post_rgb_data, exp[j-1]); end
        end
      end
    end
    bus.pre_rgb_en = 1'b0;
  endtask

  task automatic test_reset_in_pend();
    logic [23:0] q;
    logic e1, e2;
    cfg_write(2'd3, 8'h12, 8'h99);
    do_commit();
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL rstpend_busy_pre: got %b want 1", bus.cfg_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL rstpend_bank: got %b want 0", bus.active_bank); end
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL rstpend_busy: got %b want 1", bus.cfg_busy); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL rstpend_init_done: got %b want 0", bus.init_done); end
    tick(256);
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL rstpend_reinit: got %b want 1", bus.init_done); end
    send_pixel(24'h123456, 1'b1, q, e1, e2);
    checks++; if (q !== 24'h123456) begin errors++; $display("FAIL rstpend_identity: got %h want 123456", q); end
    bus.pre_vsync = 1'b1;
    tick();
    bus.pre_vsync = 1'b0;
    tick();
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL rstpend_commit_lost: got %b want 0", bus.active_bank); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.gamma_en     = 1'b1;
    bus.pre_rgb_data = '0;
    bus.pre_rgb_en   = 1'b0;
    bus.pre_vsync    = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_wdata    = '0;
    bus.cfg_commit   = 1'b0;
    test_reset();
    test_init();
    test_swap();
    test_commit_on_edge();
    test_write_in_pend();
    test_bypass();
    test_back_to_back();
    test_reset_in_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
